// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package stream_mux_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int MODE_RR    = 0;  // rotating priority, pointer moves after each packet
  localparam int MODE_FIXED = 1;  // lowest valid channel index always wins

  // Packet-level FSM: IDLE arbitrates every cycle, LOCKED holds one channel until its last beat.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational one-hot arbiter. Rotates the request vector so that the pointer
// channel lands at bit 0, picks the lowest set bit, then rotates the grant back.
// Fixed-priority mode simply forces the rotation amount to zero.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int MODE   = MODE_RR,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt
);

  logic [CH_W-1:0]   eff_ptr;
  logic [NUM_CH-1:0] rot;
  logic [NUM_CH-1:0] low;

  // Double-width rotate-and-mask grant computation.
  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    eff_ptr = (MODE == MODE_FIXED) ? '0 : ptr;
    rot     = NUM_CH'({req, req} >> eff_ptr);
    low     = rot & (~rot + NUM_CH'(1));
    gnt     = NUM_CH'(({low, low} << eff_ptr) >> NUM_CH);
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with per-packet grant locking.
// An arbiter picks a channel in IDLE; a multi-beat packet then locks the
// grant until its last beat has been accepted into the output register.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 4,
  parameter int MODE   = MODE_RR,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [NUM_CH-1:0] arb_gnt;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] accept;
  logic              capacity;
  logic              xfer;
  logic [CH_W-1:0]   sel_ch;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_arb (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Grant, ready and selection of the accepted beat.
  always_comb begin
    capacity = !out_valid_q || out_ready;
    grant    = (state_q == ST_LOCKED) ? (NUM_CH'(1) << lock_ch_q) : arb_gnt;
    in_ready = rst_n ? (grant & {NUM_CH{capacity}}) : '0;
    accept   = in_valid & in_ready;
    xfer     = |accept;
    sel_ch   = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        sel_ch   = CH_W'(i);
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Next-state logic: FSM, lock, pointer and output register.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = sel_ch;
      out_valid_d = 1'b1;
      if (sel_last) begin
        state_d = ST_IDLE;
        if (MODE == MODE_RR) begin
          rr_ptr_d = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);
        end
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = sel_ch;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any lock and any beat in flight.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin and a fixed-priority
// instance share one stimulus set; expected values are hand-computed.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fp_in_ready;
  logic [3:0]  rr_out_data, fp_out_data;
  logic        rr_out_valid, fp_out_valid;
  logic        rr_out_last, fp_out_last;
  logic [1:0]  rr_out_ch, fp_out_ch;

  int n_checks = 0;
  int n_errors = 0;

  stream_mux_rr #(.NUM_CH(4), .WIDTH(4), .MODE(0)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_valid (rr_out_valid),
    .out_last  (rr_out_last),
    .out_ch    (rr_out_ch),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.NUM_CH(4), .WIDTH(4), .MODE(1)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_last  (fp_out_last),
    .out_ch    (fp_out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr_out(input string tag, input logic [3:0] d, input logic [1:0] ch,
                              input logic last);
    check({tag, "_valid"}, rr_out_valid, 1'b1);
    check({tag, "_data"},  rr_out_data,  d);
    check({tag, "_ch"},    rr_out_ch,    ch);
    check({tag, "_last"},  rr_out_last,  last);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 16'h3210;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;

    // Reset state, with every input valid
    #3;
    check("rst_out_valid", rr_out_valid, 1'b0);
    check("rst_out_data",  rr_out_data,  4'h0);
    check("rst_out_ch",    rr_out_ch,    2'd0);
    check("rst_out_last",  rr_out_last,  1'b0);
    check("rst_in_ready",  rr_in_ready,  4'b0000);
    check("rst_fp_in_ready", fp_in_ready, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: single beat on ch2
    in_valid = 4'b0100;
    in_last  = 4'b0100;
    in_data  = 16'h0500;
    #1;
    check("t1_in_ready", rr_in_ready, 4'b0100);
    tick();
    check_rr_out("t1_out", 4'h5, 2'd2, 1'b1);

    // 2: fairness, pointer now 3 so ch3 goes first
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    in_data  = 16'h3210;
    #1;
    check("t2_in_ready_first", rr_in_ready, 4'b1000);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_rr_out("t2_seq", 4'((3 + k) % 4), 2'((3 + k) % 4), 1'b1);
    end
    in_valid = 4'b0000;
    tick();
    check("t2_drain_valid", rr_out_valid, 1'b0);

    // 3: packet lock on ch1 (pointer 1) with ch0 valid throughout
    in_valid = 4'b0011;
    in_last  = 4'b0001;
    in_data  = 16'h00A7;
    #1;
    check("t3_a_in_ready", rr_in_ready, 4'b0010);
    tick();
    check_rr_out("t3_a", 4'hA, 2'd1, 1'b0);
    in_valid = 4'b0001;               // gap on the locked channel
    #1;
    check("t3_gap_in_ready", rr_in_ready, 4'b0010);
    tick();
    check("t3_gap_valid", rr_out_valid, 1'b0);
    in_valid = 4'b0011;
    in_data  = 16'h00B7;
    #1;
    check("t3_b_in_ready", rr_in_ready, 4'b0010);
    tick();
    check_rr_out("t3_b", 4'hB, 2'd1, 1'b0);
    in_data  = 16'h00C7;
    in_last  = 4'b0011;
    #1;
    check("t3_c_in_ready", rr_in_ready, 4'b0010);
    tick();
    check_rr_out("t3_c", 4'hC, 2'd1, 1'b1);
    in_valid = 4'b0001;
    #1;
    check("t3_ch0_in_ready", rr_in_ready, 4'b0001);
    tick();
    check_rr_out("t3_ch0", 4'h7, 2'd0, 1'b1);

    // 4: backpressure for 3 cycles with ch2 waiting
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    in_data   = 16'h0900;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_in_ready", rr_in_ready, 4'b0000);
      tick();
      check_rr_out("t4_hold", 4'h7, 2'd0, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("t4_resume_in_ready", rr_in_ready, 4'b0100);
    tick();
    check_rr_out("t4_after", 4'h9, 2'd2, 1'b1);
    in_valid = 4'b0000;
    tick();
    check("t4_no_dup", rr_out_valid, 1'b0);

    // 6: reset in the middle of a 3-beat ch2 packet (pointer 3)
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    in_data  = 16'h0100;
    tick();
    check_rr_out("t6_beat1", 4'h1, 2'd2, 1'b0);
    in_data = 16'h0200;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    rr_out_valid, 1'b0);
    check("t6_rst_data",     rr_out_data,  4'h0);
    check("t6_rst_ch",       rr_out_ch,    2'd0);
    check("t6_rst_last",     rr_out_last,  1'b0);
    check("t6_rst_in_ready", rr_in_ready,  4'b0000);
    #2;
    rst_n    = 1'b1;
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    in_data  = 16'hD00C;
    #1;
    check("t6_rearb_in_ready", rr_in_ready, 4'b0001);
    tick();
    check_rr_out("t6_rearb", 4'hC, 2'd0, 1'b1);

    // 5: fixed priority starves ch3, round-robin alternates (rr pointer 1)
    in_valid = 4'b1010;
    in_last  = 4'b1010;
    in_data  = 16'h3010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_fp_in_ready", fp_in_ready, 4'b0010);
      check("t5_rr_in_ready", rr_in_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
      check("t5_fp_ch",    fp_out_ch,    2'd1);
      check("t5_fp_data",  fp_out_data,  4'h1);
      check("t5_fp_valid", fp_out_valid, 1'b1);
      check("t5_rr_ch",    rr_out_ch,    (k % 2 == 0) ? 2'd1 : 2'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stream_mux_rr
